player_motion: RTL and testbench

Parametrised vertical-motion engine for the dino sprite, the successor to the fixed-width jump/gravity block. It keeps the two-phase game-tick scheme: velocity update, then position update. It adds configurable widths, terminal-velocity and ceiling saturation, variable jump height (hold-to-extend), air jumps (double jump), a latched jump request, and a registered landing pulse. It sits between the input debouncer/edge detector and the sprite renderer/collision logic.

---
 rtl/player_motion.sv | 140 ++++++++++++++
 tb/tb_player_motion.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Vertical motion engine for the dino sprite: gravity, jumps, fast drop.
// Velocity and position advance on separate game-tick phases.
module player_motion #(
   parameter int POS_WIDTH             = 6,
   parameter int VEL_WIDTH             = 4,
   parameter int INITIAL_JUMP_VELOCITY = -7,
   parameter int DOWNWARD_ACCELERATION = 1,
   parameter int FASTDROP_VELOCITY     = 6,
   parameter int MAX_FALL_VELOCITY     = 6,
   parameter int HOLD_TICKS            = 2,
   parameter int MAX_AIR_JUMPS         = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  game_tick,
   input  logic                        jump_pulse,
   input  logic                        jump_held,
   input  logic                        button_down,
   output logic signed [POS_WIDTH-1:0] position,
   output logic signed [VEL_WIDTH-1:0] velocity,
   output logic                        airborne,
   output logic                        jump_done
);

   typedef enum logic {GROUND, AIR} state_t;

   localparam int HW = $clog2(HOLD_TICKS + 2);
   localparam int AW = $clog2(MAX_AIR_JUMPS + 2);

   localparam logic signed [VEL_WIDTH-1:0] JUMP_V =
      VEL_WIDTH'(INITIAL_JUMP_VELOCITY);
   localparam logic signed [VEL_WIDTH-1:0] FAST_V =
      VEL_WIDTH'(FASTDROP_VELOCITY);
   localparam logic signed [VEL_WIDTH-1:0] MAXF_V =
      VEL_WIDTH'(MAX_FALL_VELOCITY);
   localparam logic signed [VEL_WIDTH:0] MAXF_X =
      (VEL_WIDTH+1)'(MAX_FALL_VELOCITY);
   localparam logic signed [VEL_WIDTH:0] ACC_X =
      (VEL_WIDTH+1)'(DOWNWARD_ACCELERATION);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
   localparam logic [AW-1:0] AIRJ_INIT = AW'(MAX_AIR_JUMPS);
   localparam logic signed [POS_WIDTH:0] POS_MIN =
      {2'b11, {(POS_WIDTH-1){1'b0}}};

   state_t                      state_q, state_d;
   logic signed [POS_WIDTH-1:0] pos_q, pos_d;
   logic signed [VEL_WIDTH-1:0] vel_q, vel_d;
   logic                        pending_q, pending_d;
   logic [HW-1:0]               hold_q, hold_d;
   logic [AW-1:0]               airj_q, airj_d;
   logic                        done_q, done_d;

   logic                        pending_w;
   logic signed [VEL_WIDTH:0]   vel_inc;
   logic signed [VEL_WIDTH-1:0] vel_fall;
   logic signed [POS_WIDTH:0]   sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= GROUND;
         pos_q     <= '0;
         vel_q     <= '0;
         pending_q <= 1'b0;
         hold_q    <= '0;
         airj_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         vel_q     <= vel_d;
         pending_q <= pending_d;
         hold_q    <= hold_d;
         airj_q    <= airj_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      vel_d     = vel_q;
      hold_d    = hold_q;
      airj_d    = airj_q;
      done_d    = 1'b0;
      pending_w = pending_q | jump_pulse;
      // every velocity tick either uses the request or drops it
      pending_d = game_tick[0] ? 1'b0 : pending_w;

      vel_inc  = {vel_q[VEL_WIDTH-1], vel_q} + ACC_X;
      vel_fall = (vel_inc > MAXF_X) ? MAXF_V : vel_inc[VEL_WIDTH-1:0];
      sum      = {pos_q[POS_WIDTH-1], pos_q}
               + {{(POS_WIDTH+1-VEL_WIDTH){vel_q[VEL_WIDTH-1]}}, vel_q};

      unique case (state_q)
         GROUND: begin
            if (game_tick[0] && pending_w && !button_down) begin
               vel_d   = JUMP_V;
               hold_d  = HOLD_INIT;
               airj_d  = AIRJ_INIT;
               state_d = AIR;
            end
         end
         AIR: begin
            if (game_tick[0]) begin
               if (button_down) begin
                  vel_d  = FAST_V;
                  hold_d = '0;
               end else if (pending_w && airj_q != '0) begin
                  vel_d  = JUMP_V;
                  airj_d = airj_q - AW'(1);
                  hold_d = HOLD_INIT;
               end else if (jump_held && hold_q != '0 &&
                            vel_q[VEL_WIDTH-1]) begin
                  hold_d = hold_q - HW'(1);
               end else begin
                  vel_d = vel_fall;
               end
               if (!jump_held) hold_d = '0;
            end else if (game_tick[1]) begin
               if (!sum[POS_WIDTH]) begin
                  pos_d   = '0;
                  vel_d   = '0;
                  state_d = GROUND;
                  done_d  = 1'b1;
               end else if (sum < POS_MIN) begin
                  pos_d = POS_MIN[POS_WIDTH-1:0];
               end else begin
                  pos_d = sum[POS_WIDTH-1:0];
               end
            end
         end
      endcase
   end

   assign position  = pos_q;
   assign velocity  = vel_q;
   assign airborne  = (state_q == AIR);
   assign jump_done = done_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed scenarios plus
// randomized inputs against an integer reference model.
module tb_player_motion;

   localparam int PW = 6;
   localparam int VW = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [1:0]           game_tick;
   logic                 jump_pulse, jump_held, button_down;
   logic signed [PW-1:0] position;
   logic signed [VW-1:0] velocity;
   logic                 airborne, jump_done;

   int n_checks = 0;
   int n_fail   = 0;

   int m_pos, m_vel, m_hold, m_aj;
   bit m_air, m_pend, m_done;

   player_motion dut (
      .clk(clk), .reset(reset), .game_tick(game_tick),
      .jump_pulse(jump_pulse), .jump_held(jump_held),
      .button_down(button_down), .position(position),
      .velocity(velocity), .airborne(airborne),
      .jump_done(jump_done)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pos = 0; m_vel = 0; m_hold = 0; m_aj = 0;
      m_air = 0; m_pend = 0; m_done = 0;
   endtask

   // Game rules with plain integers: -7 jump, +1 gravity, cap 6, floor -32
   task automatic model_step(input logic [1:0] t, input bit p,
                             input bit h, input bit d);
      bit pend;
      int s;
      pend   = m_pend | p;
      m_done = 0;
      if (t[0]) begin
         m_pend = 0;
         if (!m_air) begin
            if (pend && !d) begin
               m_vel = -7; m_hold = 2; m_aj = 1; m_air = 1;
            end
         end else begin
            if (d) begin
               m_vel = 6; m_hold = 0;
            end else if (pend && m_aj > 0) begin
               m_vel = -7; m_aj--; m_hold = 2;
            end else if (h && m_hold > 0 && m_vel < 0) begin
               m_hold--;
            end else begin
               m_vel = (m_vel + 1 > 6) ? 6 : m_vel + 1;
            end
            if (!h) m_hold = 0;
         end
      end else begin
         m_pend = pend;
         if (t[1] && m_air) begin
            s = m_pos + m_vel;
            if (s >= 0) begin
               m_pos = 0; m_vel = 0; m_air = 0; m_done = 1;
            end else if (s < -32) m_pos = -32;
            else m_pos = s;
         end
      end
   endtask

   task automatic step(input logic [1:0] t, input bit p,
                       input bit h, input bit d);
      game_tick = t; jump_pulse = p; jump_held = h; button_down = d;
      @(posedge clk);
      if (reset) model_reset();
      else model_step(t, p, h, d);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      game_tick = 2'b00; jump_pulse = 0; jump_held = 0; button_down = 0;
      model_reset();
      #12;
      n_checks++;
      if (position !== 6'sd0 || velocity !== 4'sd0 ||
          airborne !== 1'b0 || jump_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got pos=%0d vel=%0d air=%b done=%b want 0",
                  position, velocity, airborne, jump_done);
      end
      @(negedge clk);
      reset = 1'b0;
      step(2'b01, 0, 0, 0);
      n_checks++;
      if (airborne !== 1'b0 || velocity !== 4'sd0) begin
         n_fail++;
         $display("FAIL reset_idle: got air=%b vel=%0d want 0 0",
                  airborne, velocity);
      end
   endtask

   task automatic test_single_jump();
      int ev[16] = '{-7,-6,-5,-4,-3,-2,-1,0,1,2,3,4,5,6,6,6};
      int ep[16] = '{-7,-13,-18,-22,-25,-27,-28,-28,
                     -27,-25,-22,-18,-13,-7,-1,0};
      int dones = 0;
      step(2'b00, 1, 0, 0);
      step(2'b00, 0, 0, 0);
      for (int f = 0; f < 16; f++) begin
         step(2'b01, 0, 0, 0);
         if (jump_done) dones++;
         n_checks++;
         if (velocity !== 4'(ev[f])) begin
            n_fail++;
            $display("FAIL single_vel[%0d]: got %0d want %0d",
                     f, velocity, ev[f]);
         end
         step(2'b10, 0, 0, 0);
         if (jump_done) dones++;
         n_checks++;
         if (position !== 6'(ep[f])) begin
            n_fail++;
            $display("FAIL single_pos[%0d]: got %0d want %0d",
                     f, position, ep[f]);
         end
      end
      n_checks++;
      if (jump_done !== 1'b1 || airborne !== 1'b0 || velocity !== 4'sd0) begin
         n_fail++;
         $display("FAIL single_land: got done=%b air=%b vel=%0d want 1 0 0",
                  jump_done, airborne, velocity);
      end
      for (int i = 0; i < 4; i++) begin
         step(2'(i & 1 ? 2 : 1), 0, 0, 0);
         if (jump_done) dones++;
      end
      n_checks++;
      if (dones != 1) begin
         n_fail++;
         $display("FAIL single_done_count: got %0d want 1", dones);
      end
   endtask

   task automatic test_held_jump();
      int hv[18] = '{-7,-7,-7,-6,-5,-4,-3,-2,-1,0,1,2,3,4,5,6,6,6};
      int hp[18] = '{-7,-14,-21,-27,-32,-32,-32,-32,-32,
                     -32,-31,-29,-26,-22,-17,-11,-5,0};
      for (int f = 0; f < 18; f++) begin
         step(2'b01, f == 0, 1, 0);
         n_checks++;
         if (velocity !== 4'(hv[f])) begin
            n_fail++;
            $display("FAIL held_vel[%0d]: got %0d want %0d",
                     f, velocity, hv[f]);
         end
         step(2'b10, 0, 1, 0);
         n_checks++;
         if (position !== 6'(hp[f])) begin
            n_fail++;
            $display("FAIL held_pos[%0d]: got %0d want %0d",
                     f, position, hp[f]);
         end
      end
      n_checks++;
      if (airborne !== 1'b0 || jump_done !== 1'b1) begin
         n_fail++;
         $display("FAIL held_land: got air=%b done=%b want 0 1",
                  airborne, jump_done);
      end
      step(2'b00, 0, 0, 0);
   endtask

   task automatic test_double_jump();
      for (int f = 0; f < 8; f++) begin
         step(2'b01, f == 0, 0, 0);
         step(2'b10, 0, 0, 0);
      end
      n_checks++;
      if (position !== -6'sd28 || velocity !== 4'sd0) begin
         n_fail++;
         $display("FAIL dbl_apex: got pos=%0d vel=%0d want -28 0",
                  position, velocity);
      end
      step(2'b01, 1, 0, 0);
      n_checks++;
      if (velocity !== -4'sd7) begin
         n_fail++;
         $display("FAIL dbl_vel: got %0d want -7", velocity);
      end
      step(2'b10, 0, 0, 0);
      n_checks++;
      if (position !== -6'sd32) begin
         n_fail++;
         $display("FAIL dbl_clamp: got %0d want -32", position);
      end
      step(2'b00, 1, 0, 0);
      step(2'b01, 0, 0, 0);
      n_checks++;
      if (velocity !== -4'sd6) begin
         n_fail++;
         $display("FAIL third_ignored: got vel=%0d want -6", velocity);
      end
      step(2'b10, 0, 0, 0);
      for (int i = 0; i < 40 && airborne; i++) begin
         step(2'b01, 0, 0, 0);
         step(2'b10, 0, 0, 0);
      end
      n_checks++;
      if (airborne !== 1'b0 || position !== 6'sd0) begin
         n_fail++;
         $display("FAIL dbl_land: got air=%b pos=%0d want 0 0",
                  airborne, position);
      end
      step(2'b01, 0, 0, 0);
      step(2'b00, 0, 0, 0);
      step(2'b01, 0, 0, 0);
      n_checks++;
      if (airborne !== 1'b0 || velocity !== 4'sd0) begin
         n_fail++;
         $display("FAIL dbl_no_pending: got air=%b vel=%0d want 0 0",
                  airborne, velocity);
      end
   endtask

   task automatic test_fast_drop();
      int fp[4] = '{-16,-10,-4,0};
      for (int f = 0; f < 4; f++) begin
         step(2'b01, f == 0, 0, 0);
         step(2'b10, 0, 0, 0);
      end
      n_checks++;
      if (position !== -6'sd22) begin
         n_fail++;
         $display("FAIL fast_start: got %0d want -22", position);
      end
      for (int f = 0; f < 4; f++) begin
         step(2'b01, 0, 0, 1);
         n_checks++;
         if (velocity !== 4'sd6) begin
            n_fail++;
            $display("FAIL fast_vel[%0d]: got %0d want 6", f, velocity);
         end
         step(2'b10, 0, 0, 1);
         n_checks++;
         if (position !== 6'(fp[f])) begin
            n_fail++;
            $display("FAIL fast_pos[%0d]: got %0d want %0d",
                     f, position, fp[f]);
         end
      end
      step(2'b00, 1, 0, 1);
      step(2'b01, 0, 0, 1);
      n_checks++;
      if (airborne !== 1'b0 || velocity !== 4'sd0) begin
         n_fail++;
         $display("FAIL down_blocks_jump: got air=%b vel=%0d want 0 0",
                  airborne, velocity);
      end
      step(2'b01, 0, 0, 0);
      n_checks++;
      if (airborne !== 1'b0) begin
         n_fail++;
         $display("FAIL down_clears_pending: got air=%b want 0", airborne);
      end
   endtask

   task automatic test_pending_and_tick11();
      step(2'b00, 1, 0, 0);
      step(2'b00, 0, 0, 0);
      step(2'b10, 0, 0, 0);
      n_checks++;
      if (airborne !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_wait: got air=%b want 0", airborne);
      end
      step(2'b01, 0, 0, 0);
      n_checks++;
      if (airborne !== 1'b1 || velocity !== -4'sd7) begin
         n_fail++;
         $display("FAIL pend_jump: got air=%b vel=%0d want 1 -7",
                  airborne, velocity);
      end
      step(2'b11, 0, 0, 0);
      n_checks++;
      if (velocity !== -4'sd6 || position !== 6'sd0) begin
         n_fail++;
         $display("FAIL tick11: got vel=%0d pos=%0d want -6 0",
                  velocity, position);
      end
      step(2'b10, 0, 0, 0);
      n_checks++;
      if (position !== -6'sd6) begin
         n_fail++;
         $display("FAIL tick11_pos: got %0d want -6", position);
      end
      for (int i = 0; i < 40 && airborne; i++) begin
         step(2'b01, 0, 0, 0);
         step(2'b10, 0, 0, 0);
      end
      step(2'b00, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      int dones = 0;
      for (int f = 0; f < 3; f++) begin
         step(2'b01, f == 0, 0, 0);
         step(2'b10, 0, 0, 0);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (position !== 6'sd0 || velocity !== 4'sd0 ||
          airborne !== 1'b0 || jump_done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got pos=%0d vel=%0d air=%b done=%b want 0",
                  position, velocity, airborne, jump_done);
      end
      @(negedge clk);
      step(2'b01, 0, 0, 0);
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step((i % 2 == 0) ? 2'b01 : 2'b10, 0, 0, 0);
         if (jump_done || airborne) dones++;
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL post_reset_quiet: got %0d active cycles want 0", dones);
      end
   endtask

   task automatic test_random();
      bit h = 0, d = 0, p;
      logic [1:0] t;
      for (int c = 0; c < 4000; c++) begin
         t = 2'($urandom_range(0, 3));
         p = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 5) == 0) h = ~h;
         if ($urandom_range(0, 11) == 0) d = ~d;
         step(t, p, h, d);
         n_checks++;
         if (position !== 6'(m_pos) || velocity !== 4'(m_vel) ||
             airborne !== m_air || jump_done !== m_done) begin
            n_fail++;
            $display("FAIL rand[%0d]: got pos=%0d vel=%0d air=%b done=%b want %0d %0d %b %b",
                     c, position, velocity, airborne, jump_done,
                     m_pos, m_vel, m_air, m_done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_jump();
      test_held_jump();
      test_double_jump();
      test_fast_drop();
      test_pending_and_tick11();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
